vr_log_mem_arb: RTL and testbench

//  Shares the single VR log-memory command port between the prepare engine (req 0, log appends)
//  and the commit engine (req 1, entry read / state-update write). Round-robin per command;

---
 rtl/vr_log_mem_arb.sv | 158 +++++++++++++++
 tb/tb_vr_log_mem_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vr_log_mem_arb.sv
// Round-robin arbiter sharing the VR log-memory command port between the prepare and commit engines.
// Read responses are steered back through an in-order tag FIFO. Optional: LOG_ARB_WR_PRIO_EN.
module vr_log_mem_arb #(
  parameter int NOC_DATA_W      = 512,
  parameter int LOG_ADDR_W      = 12,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prep_cmd_val,
  input  logic                  prep_cmd_wr,
  input  logic [LOG_ADDR_W-1:0] prep_cmd_addr,
  input  logic [NOC_DATA_W-1:0] prep_cmd_data,
  output logic                  arb_prep_cmd_rdy,
  output logic                  arb_prep_rd_resp_val,
  output logic [NOC_DATA_W-1:0] arb_prep_rd_resp_data,
  input  logic                  prep_arb_rd_resp_rdy,
  input  logic                  commit_cmd_val,
  input  logic                  commit_cmd_wr,
  input  logic [LOG_ADDR_W-1:0] commit_cmd_addr,
  input  logic [NOC_DATA_W-1:0] commit_cmd_data,
  output logic                  arb_commit_cmd_rdy,
  output logic                  arb_commit_rd_resp_val,
  output logic [NOC_DATA_W-1:0] arb_commit_rd_resp_data,
  input  logic                  commit_arb_rd_resp_rdy,
  output logic                  arb_mem_cmd_val,
  output logic                  arb_mem_cmd_wr,
  output logic [LOG_ADDR_W-1:0] arb_mem_cmd_addr,
  output logic [NOC_DATA_W-1:0] arb_mem_cmd_data,
  input  logic                  mem_arb_cmd_rdy,
  input  logic                  mem_arb_rd_resp_val,
  input  logic [NOC_DATA_W-1:0] mem_arb_rd_resp_data,
  output logic                  arb_mem_rd_resp_rdy,
  output logic                  arb_idle,
  output logic                  arb_resp_err
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic                       last_grant;
  logic                       hold_q;
  logic                       hold_id_q;
  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;

  logic tag_full;
  logic tag_empty;
  logic elig0;
  logic elig1;
  logic winner;
  logic cmd_accept;
  logic push;
  logic pop;
  logic head_tag;

  assign tag_full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign tag_empty = (count == '0);
  assign elig0     = prep_cmd_val & (prep_cmd_wr | ~tag_full);
  assign elig1     = commit_cmd_val & (commit_cmd_wr | ~tag_full);
  assign head_tag  = tag_mem[rd_ptr];

  // A stalled grant is held so the downstream handshake stays stable until accepted.
  always_comb begin
    winner = 1'b0;
    if (hold_q && (hold_id_q ? elig1 : elig0)) begin
      winner = hold_id_q;
    end else if (elig0 && elig1) begin
`ifdef LOG_ARB_WR_PRIO_EN
      if (prep_cmd_wr != commit_cmd_wr) begin
        winner = commit_cmd_wr;
      end else begin
        winner = ~last_grant;
      end
`else
      winner = ~last_grant;
`endif
    end else begin
      winner = elig1;
    end
  end

  always_comb begin
    arb_mem_cmd_val    = elig0 | elig1;
    arb_mem_cmd_wr     = winner ? commit_cmd_wr   : prep_cmd_wr;
    arb_mem_cmd_addr   = winner ? commit_cmd_addr : prep_cmd_addr;
    arb_mem_cmd_data   = winner ? commit_cmd_data : prep_cmd_data;
    arb_prep_cmd_rdy   = arb_mem_cmd_val & ~winner & mem_arb_cmd_rdy;
    arb_commit_cmd_rdy = arb_mem_cmd_val & winner & mem_arb_cmd_rdy;
  end

  assign cmd_accept = arb_mem_cmd_val & mem_arb_cmd_rdy;
  assign push       = cmd_accept & ~arb_mem_cmd_wr;

  // Responses with no tag outstanding are swallowed and flagged.
  always_comb begin
    arb_prep_rd_resp_data   = mem_arb_rd_resp_data;
    arb_commit_rd_resp_data = mem_arb_rd_resp_data;
    arb_prep_rd_resp_val    = 1'b0;
    arb_commit_rd_resp_val  = 1'b0;
    arb_mem_rd_resp_rdy     = 1'b1;
    if (!tag_empty) begin
      arb_prep_rd_resp_val   = mem_arb_rd_resp_val & ~head_tag;
      arb_commit_rd_resp_val = mem_arb_rd_resp_val & head_tag;
      arb_mem_rd_resp_rdy    = head_tag ? commit_arb_rd_resp_rdy : prep_arb_rd_resp_rdy;
    end
  end

  assign pop      = mem_arb_rd_resp_val & ~tag_empty & arb_mem_rd_resp_rdy;
  assign arb_idle = ~prep_cmd_val & ~commit_cmd_val & tag_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      hold_q     <= 1'b0;
      hold_id_q  <= 1'b0;
    end else begin
      hold_q    <= arb_mem_cmd_val & ~mem_arb_cmd_rdy;
      hold_id_q <= winner;
      if (cmd_accept) begin
        last_grant <= winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= winner;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      arb_resp_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem_arb_rd_resp_val && tag_empty) begin
        arb_resp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vr_log_mem_arb.sv
// Scoreboard bench for vr_log_mem_arb: directed corner cases, then randomized traffic against a queue model.
// Honours LOG_ARB_WR_PRIO_EN the same way the design does.
module tb_vr_log_mem_arb;

  localparam int DW = 512;
  localparam int AW = 12;
  localparam int MO = 4;

  typedef struct {
    bit            eng;
    logic [DW-1:0] data;
  } resp_t;

  logic          clk;
  logic          rst;
  logic          prep_cmd_val, prep_cmd_wr;
  logic [AW-1:0] prep_cmd_addr;
  logic [DW-1:0] prep_cmd_data;
  logic          arb_prep_cmd_rdy, arb_prep_rd_resp_val;
  logic [DW-1:0] arb_prep_rd_resp_data;
  logic          prep_arb_rd_resp_rdy;
  logic          commit_cmd_val, commit_cmd_wr;
  logic [AW-1:0] commit_cmd_addr;
  logic [DW-1:0] commit_cmd_data;
  logic          arb_commit_cmd_rdy, arb_commit_rd_resp_val;
  logic [DW-1:0] arb_commit_rd_resp_data;
  logic          commit_arb_rd_resp_rdy;
  logic          arb_mem_cmd_val, arb_mem_cmd_wr;
  logic [AW-1:0] arb_mem_cmd_addr;
  logic [DW-1:0] arb_mem_cmd_data;
  logic          mem_arb_cmd_rdy, mem_arb_rd_resp_val;
  logic [DW-1:0] mem_arb_rd_resp_data;
  logic          arb_mem_rd_resp_rdy, arb_idle, arb_resp_err;

  int n_checks = 0;
  int n_pass   = 0;

  bit            mon_en = 0;
  bit            m_last, m_hold, m_hold_id;
  int            out_cnt, cnt_snap;
  bit            acc0, acc1, resp_popped;
  resp_t         exp_resp[$];
  logic [DW-1:0] mem_pend[$];
  logic [DW-1:0] mem_model [16];

  vr_log_mem_arb #(.NOC_DATA_W(DW), .LOG_ADDR_W(AW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .prep_cmd_val(prep_cmd_val), .prep_cmd_wr(prep_cmd_wr),
    .prep_cmd_addr(prep_cmd_addr), .prep_cmd_data(prep_cmd_data),
    .arb_prep_cmd_rdy(arb_prep_cmd_rdy), .arb_prep_rd_resp_val(arb_prep_rd_resp_val),
    .arb_prep_rd_resp_data(arb_prep_rd_resp_data), .prep_arb_rd_resp_rdy(prep_arb_rd_resp_rdy),
    .commit_cmd_val(commit_cmd_val), .commit_cmd_wr(commit_cmd_wr),
    .commit_cmd_addr(commit_cmd_addr), .commit_cmd_data(commit_cmd_data),
    .arb_commit_cmd_rdy(arb_commit_cmd_rdy), .arb_commit_rd_resp_val(arb_commit_rd_resp_val),
    .arb_commit_rd_resp_data(arb_commit_rd_resp_data),
    .commit_arb_rd_resp_rdy(commit_arb_rd_resp_rdy),
    .arb_mem_cmd_val(arb_mem_cmd_val), .arb_mem_cmd_wr(arb_mem_cmd_wr),
    .arb_mem_cmd_addr(arb_mem_cmd_addr), .arb_mem_cmd_data(arb_mem_cmd_data),
    .mem_arb_cmd_rdy(mem_arb_cmd_rdy), .mem_arb_rd_resp_val(mem_arb_rd_resp_val),
    .mem_arb_rd_resp_data(mem_arb_rd_resp_data), .arb_mem_rd_resp_rdy(arb_mem_rd_resp_rdy),
    .arb_idle(arb_idle), .arb_resp_err(arb_resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] randWide();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    prep_cmd_val = 0; prep_cmd_wr = 0; prep_cmd_addr = '0; prep_cmd_data = '0;
    commit_cmd_val = 0; commit_cmd_wr = 0; commit_cmd_addr = '0; commit_cmd_data = '0;
    mem_arb_cmd_rdy = 0; mem_arb_rd_resp_val = 0; mem_arb_rd_resp_data = '0;
    prep_arb_rd_resp_rdy = 0; commit_arb_rd_resp_rdy = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Randomized engines and memory; unaccepted commands and responses are held stable.
  task automatic applyStimulus();
    if (!(prep_cmd_val && !acc0)) begin
      prep_cmd_val  = ($urandom_range(0, 9) < 6);
      prep_cmd_wr   = ($urandom_range(0, 2) == 0);
      prep_cmd_addr = AW'($urandom_range(0, 4095));
      prep_cmd_data = randWide();
    end
    if (!(commit_cmd_val && !acc1)) begin
      commit_cmd_val  = ($urandom_range(0, 9) < 6);
      commit_cmd_wr   = ($urandom_range(0, 3) == 0);
      commit_cmd_addr = AW'($urandom_range(0, 4095));
      commit_cmd_data = randWide();
    end
    mem_arb_cmd_rdy = ($urandom_range(0, 9) < 7);
    if (!(mem_arb_rd_resp_val && !resp_popped)) begin
      if (mem_pend.size() > 0 && $urandom_range(0, 9) < 6) begin
        mem_arb_rd_resp_val  = 1'b1;
        mem_arb_rd_resp_data = mem_pend[0];
      end else begin
        mem_arb_rd_resp_val  = 1'b0;
      end
    end
    prep_arb_rd_resp_rdy   = ($urandom_range(0, 9) < 7);
    commit_arb_rd_resp_rdy = ($urandom_range(0, 9) < 7);
  endtask

  always @(posedge clk) cnt_snap = out_cnt;

  // Command-side model: eligibility, sticky grant, round robin (plus optional write priority).
  always @(negedge clk) begin
    if (mon_en) begin
      bit e0, e1, w, ev;
      logic [AW-1:0] a;
      e0 = prep_cmd_val && (prep_cmd_wr || cnt_snap < MO);
      e1 = commit_cmd_val && (commit_cmd_wr || cnt_snap < MO);
      ev = e0 || e1;
      if (m_hold && (m_hold_id ? e1 : e0)) w = m_hold_id;
      else if (e0 && e1) begin
`ifdef LOG_ARB_WR_PRIO_EN
        w = (prep_cmd_wr != commit_cmd_wr) ? commit_cmd_wr : !m_last;
`else
        w = !m_last;
`endif
      end else w = e1;
      a = w ? commit_cmd_addr : prep_cmd_addr;
      checkOutput("cmd_val", arb_mem_cmd_val, ev);
      if (ev) begin
        checkOutput("cmd_wr", arb_mem_cmd_wr, w ? commit_cmd_wr : prep_cmd_wr);
        checkOutput("cmd_addr", arb_mem_cmd_addr, a);
        checkOutput("cmd_data", arb_mem_cmd_data, w ? commit_cmd_data : prep_cmd_data);
      end
      checkOutput("prep_rdy", arb_prep_cmd_rdy, ev && !w && mem_arb_cmd_rdy);
      checkOutput("commit_rdy", arb_commit_cmd_rdy, ev && w && mem_arb_cmd_rdy);
      checkOutput("idle", arb_idle, !prep_cmd_val && !commit_cmd_val && cnt_snap == 0);
      checkOutput("resp_err", arb_resp_err, 1'b0);
      acc0 = ev && !w && mem_arb_cmd_rdy;
      acc1 = ev && w && mem_arb_cmd_rdy;
      if (ev && mem_arb_cmd_rdy) begin
        m_last = w;
        if (!arb_mem_cmd_wr_exp(w)) begin
          resp_t r;
          r.eng  = w;
          r.data = mem_model[a[3:0]];
          exp_resp.push_back(r);
          mem_pend.push_back(r.data);
          out_cnt++;
        end else begin
          mem_model[a[3:0]] = w ? commit_cmd_data : prep_cmd_data;
        end
      end
      m_hold    = ev && !mem_arb_cmd_rdy;
      m_hold_id = w;
    end
  end

  function automatic bit arb_mem_cmd_wr_exp(input bit w);
    return w ? commit_cmd_wr : prep_cmd_wr;
  endfunction

  // Response-side scoreboard: head of the expected queue names the engine and data.
  always @(negedge clk) begin
    if (mon_en) begin
      resp_popped = 1'b0;
      if (mem_arb_rd_resp_val && exp_resp.size() > 0) begin
        resp_t r;
        bit    rdy;
        r   = exp_resp[0];
        rdy = r.eng ? commit_arb_rd_resp_rdy : prep_arb_rd_resp_rdy;
        checkOutput("resp_prep_val", arb_prep_rd_resp_val, !r.eng);
        checkOutput("resp_commit_val", arb_commit_rd_resp_val, r.eng);
        checkOutput("resp_data", r.eng ? arb_commit_rd_resp_data : arb_prep_rd_resp_data, r.data);
        checkOutput("resp_mem_rdy", arb_mem_rd_resp_rdy, rdy);
        if (rdy) begin
          void'(exp_resp.pop_front());
          void'(mem_pend.pop_front());
          out_cnt--;
          resp_popped = 1'b1;
        end
      end else begin
        checkOutput("resp_quiet", arb_prep_rd_resp_val | arb_commit_rd_resp_val, 1'b0);
      end
    end
  end

  initial begin
    logic [DW-1:0] d [4];
    logic [DW-1:0] y;
    rst = 1'b1;
    acc0 = 0; acc1 = 0; resp_popped = 0; out_cnt = 0; cnt_snap = 0;
    for (int i = 0; i < 16; i++) mem_model[i] = randWide();
    doReset();

    @(negedge clk);
    checkOutput("rst_idle", arb_idle, 1'b1);
    checkOutput("rst_err", arb_resp_err, 1'b0);
    checkOutput("rst_cmd_val", arb_mem_cmd_val, 1'b0);
    checkOutput("rst_prep_rdy", arb_prep_cmd_rdy, 1'b0);
    checkOutput("rst_commit_rdy", arb_commit_cmd_rdy, 1'b0);
    checkOutput("rst_resp_val", arb_prep_rd_resp_val | arb_commit_rd_resp_val, 1'b0);

    // Both engines read continuously: grants alternate starting with prep.
    @(posedge clk); #1;
    prep_cmd_val = 1; prep_cmd_wr = 0; prep_cmd_addr = 12'h010;
    commit_cmd_val = 1; commit_cmd_wr = 0; commit_cmd_addr = 12'h020;
    mem_arb_cmd_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rr_addr", arb_mem_cmd_addr, (i % 2 == 0) ? 12'h010 : 12'h020);
    end
    @(posedge clk); #1;
    prep_cmd_val = 0; commit_cmd_val = 0;
    prep_arb_rd_resp_rdy = 1; commit_arb_rd_resp_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      d[i] = randWide();
      mem_arb_rd_resp_val = 1; mem_arb_rd_resp_data = d[i];
      @(negedge clk);
      checkOutput("steer_prep_val", arb_prep_rd_resp_val, i % 2 == 0);
      checkOutput("steer_commit_val", arb_commit_rd_resp_val, i % 2 == 1);
      checkOutput("steer_data", (i % 2 == 0) ? arb_prep_rd_resp_data : arb_commit_rd_resp_data, d[i]);
      @(posedge clk); #1;
    end
    mem_arb_rd_resp_val = 0;
    @(negedge clk);
    checkOutput("drain_idle", arb_idle, 1'b1);

    // Fill the tag FIFO with commit reads; writes pass, reads stall until a pop.
    doReset();
    commit_cmd_val = 1; commit_cmd_wr = 0; mem_arb_cmd_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      commit_cmd_addr = 12'h100 + 12'(i);
      @(posedge clk); #1;
    end
    commit_cmd_addr = 12'h155;
    prep_cmd_val = 1; prep_cmd_wr = 1; prep_cmd_addr = 12'h033; prep_cmd_data = randWide();
    @(negedge clk);
    checkOutput("full_wr_val", arb_mem_cmd_val, 1'b1);
    checkOutput("full_wr_wr", arb_mem_cmd_wr, 1'b1);
    checkOutput("full_wr_addr", arb_mem_cmd_addr, 12'h033);
    checkOutput("full_wr_prep_rdy", arb_prep_cmd_rdy, 1'b1);
    checkOutput("full_wr_commit_rdy", arb_commit_cmd_rdy, 1'b0);
    @(posedge clk); #1;
    prep_cmd_val = 0;
    @(negedge clk);
    checkOutput("full_rd_stall", arb_mem_cmd_val, 1'b0);
    checkOutput("full_rd_rdy", arb_commit_cmd_rdy, 1'b0);
    checkOutput("full_not_idle", arb_idle, 1'b0);
    @(posedge clk); #1;
    y = randWide();
    mem_arb_rd_resp_val = 1; mem_arb_rd_resp_data = y; commit_arb_rd_resp_rdy = 1;
    @(negedge clk);
    checkOutput("full_resp_val", arb_commit_rd_resp_val, 1'b1);
    checkOutput("full_resp_data", arb_commit_rd_resp_data, y);
    checkOutput("full_resp_rdy", arb_mem_rd_resp_rdy, 1'b1);
    checkOutput("full_resp_stall", arb_mem_cmd_val, 1'b0);
    @(posedge clk); #1;
    mem_arb_rd_resp_val = 0;
    @(negedge clk);
    checkOutput("unstall_val", arb_mem_cmd_val, 1'b1);
    checkOutput("unstall_addr", arb_mem_cmd_addr, 12'h155);
    checkOutput("unstall_rdy", arb_commit_cmd_rdy, 1'b1);

    // Reset with reads in flight, then a stray response sets the sticky error.
    doReset();
    @(negedge clk);
    checkOutput("midrst_idle", arb_idle, 1'b1);
    @(posedge clk); #1;
    mem_arb_rd_resp_val = 1; mem_arb_rd_resp_data = randWide();
    @(negedge clk);
    checkOutput("stray_rdy", arb_mem_rd_resp_rdy, 1'b1);
    checkOutput("stray_vals", arb_prep_rd_resp_val | arb_commit_rd_resp_val, 1'b0);
    checkOutput("stray_err_pre", arb_resp_err, 1'b0);
    @(posedge clk); #1;
    mem_arb_rd_resp_val = 0;
    @(negedge clk);
    checkOutput("stray_err", arb_resp_err, 1'b1);
    @(negedge clk);
    checkOutput("stray_err_sticky", arb_resp_err, 1'b1);
    doReset();
    @(negedge clk);
    checkOutput("err_cleared", arb_resp_err, 1'b0);

    // Stalled grant stays with commit even when prep shows up.
    @(posedge clk); #1;
    commit_cmd_val = 1; commit_cmd_wr = 0; commit_cmd_addr = 12'h066; mem_arb_cmd_rdy = 0;
    @(negedge clk);
    checkOutput("hold_first", arb_mem_cmd_addr, 12'h066);
    @(posedge clk); #1;
    prep_cmd_val = 1; prep_cmd_wr = 1; prep_cmd_addr = 12'h044;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_addr", arb_mem_cmd_addr, 12'h066);
      checkOutput("hold_prep_rdy", arb_prep_cmd_rdy, 1'b0);
    end
    @(posedge clk); #1;
    mem_arb_cmd_rdy = 1;
    @(negedge clk);
    checkOutput("hold_release", arb_commit_cmd_rdy, 1'b1);

    // Write vs read tie, first with last_grant=1 then with last_grant=0.
    doReset();
    prep_cmd_val = 1; prep_cmd_wr = 1; prep_cmd_addr = 12'h044;
    commit_cmd_val = 1; commit_cmd_wr = 0; commit_cmd_addr = 12'h066;
    @(negedge clk);
    checkOutput("prio_lg1_addr", arb_mem_cmd_addr, 12'h044);
    doReset();
    prep_cmd_val = 1; prep_cmd_wr = 0; prep_cmd_addr = 12'h011; mem_arb_cmd_rdy = 1;
    @(posedge clk); #1;
    prep_cmd_wr = 1; prep_cmd_addr = 12'h044;
    commit_cmd_val = 1; commit_cmd_wr = 0; commit_cmd_addr = 12'h066;
    @(negedge clk);
`ifdef LOG_ARB_WR_PRIO_EN
    checkOutput("prio_lg0_addr", arb_mem_cmd_addr, 12'h044);
    checkOutput("prio_lg0_rdy", arb_prep_cmd_rdy, 1'b1);
`else
    checkOutput("prio_lg0_addr", arb_mem_cmd_addr, 12'h066);
    checkOutput("prio_lg0_rdy", arb_commit_cmd_rdy, 1'b1);
`endif

    // Randomized traffic against the scoreboard.
    doReset();
    m_last = 1; m_hold = 0; m_hold_id = 0; out_cnt = 0; cnt_snap = 0;
    acc0 = 0; acc1 = 0; resp_popped = 0;
    exp_resp.delete(); mem_pend.delete();
    mon_en = 1;
    repeat (3000) begin
      @(posedge clk); #1;
      applyStimulus();
    end
    @(posedge clk); #1;
    mon_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
